// File: rtl/tt_sweep_capture.sv
// Sweeps every input minterm of a combinational netlist, captures its output truth table, and compares it against an expected table.
// done is pulsed 2**NUM_PI*(SETTLE_CYCLES+1)+1 edges after start is accepted; all outputs are registered.
// start is accepted only in IDLE, never queued; abort cancels a running sweep at the next edge.
module tt_sweep_capture #(
  parameter int NUM_PI        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**NUM_PI-1:0] expected,
  output logic [NUM_PI-1:0]    pi,
  input  logic                 po,
  output logic                 busy,
  output logic                 done,
  output logic [2**NUM_PI-1:0] tt,
  output logic                 match,
  output logic [NUM_PI:0]      mismatch_count,
  output logic [NUM_PI-1:0]    first_fail,
  output logic                 first_fail_valid
);

  localparam int W  = 2**NUM_PI;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [NUM_PI-1:0] PI_LAST  = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // With no settle time the sweep goes straight from one sample to the next.
  localparam state_t STEP = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;

  state_t          state_q, state_nxt;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    exp_q;
  logic            accept, sample, cancel, finish;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic and one-hot action strobes for the datapath.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    sample    = 1'b0;
    cancel    = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = STEP;
        end
      end
      DRIVE: begin
        if (abort) begin
          cancel    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        // an abort here drops the pending sample of the current minterm
        if (abort) begin
          cancel    = 1'b1;
          state_nxt = IDLE;
        end else begin
          sample    = 1'b1;
          state_nxt = (pi == PI_LAST) ? DONE : STEP;
        end
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Settle counter: runs only while staying in DRIVE, restarts on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     cnt_q <= '0;
    else if (state_q == DRIVE && state_nxt == DRIVE) cnt_q <= cnt_q + CW'(1);
    else                                            cnt_q <= '0;
  end

  // Registered outputs: minterm drive, capture, mismatch bookkeeping and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi               <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      tt               <= '0;
      match            <= 1'b0;
      mismatch_count   <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      exp_q            <= '0;
    end else begin
      busy <= (state_nxt == DRIVE) || (state_nxt == SAMPLE);
      done <= finish;
      if (accept) begin
        exp_q            <= expected;
        tt               <= '0;
        mismatch_count   <= '0;
        first_fail       <= '0;
        first_fail_valid <= 1'b0;
        match            <= 1'b0;
        pi               <= '0;
      end
      if (sample) begin
        tt[pi] <= po;
        if (po != exp_q[pi]) begin
          mismatch_count <= mismatch_count + (NUM_PI+1)'(1);
          if (!first_fail_valid) begin
            first_fail       <= pi;
            first_fail_valid <= 1'b1;
          end
        end
        // the last minterm is left on pi rather than wrapping to 0
        if (pi != PI_LAST) pi <= pi + NUM_PI'(1);
      end
      if (cancel) begin
        pi    <= '0;
        match <= 1'b0;
      end
      if (finish) match <= (mismatch_count == '0);
    end
  end

endmodule
